// File: rtl/comparator_tree128.sv
// comparator_tree128: registered 128-bit EQ / signed LT / unsigned LT flags from a 7-level merge tree.
// Build option COMPARATOR_TREE128_PIPE_EN adds a register stage after merge level 4 (latency 2).
module comparator_tree128 (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] op1,
    input  logic [127:0] op2,
    output logic         EQ,
    output logic         LT,
    output logic         LTu
);
    // Heap-ordered nodes: level k starts at 256 - (256 >> k) with 128 >> k cells; root at 254.
    logic [254:0] e_n, l_n;
    logic [7:0]   e4_src, l4_src;
    logic         sgn_src;
    logic         eq_d, lt_d, ltu_d;
    logic         eq_q, lt_q, ltu_q;

    assign e_n[127:0] = ~(op1 ^ op2);
    assign l_n[127:0] = ~op1 & op2;

`ifdef COMPARATOR_TREE128_PIPE_EN
    logic [7:0] e4_q, l4_q;
    logic       sgn_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e4_q  <= '0;
            l4_q  <= '0;
            sgn_q <= 1'b0;
        end else begin
            e4_q  <= e_n[247:240];
            l4_q  <= l_n[247:240];
            sgn_q <= op1[127] ^ op2[127];
        end
    end

    assign e4_src  = e4_q;
    assign l4_src  = l4_q;
    assign sgn_src = sgn_q;
`else
    assign e4_src  = e_n[247:240];
    assign l4_src  = l_n[247:240];
    assign sgn_src = op1[127] ^ op2[127];
`endif

    genvar k, j;
    generate
        for (k = 1; k <= 7; k++) begin : g_lvl
            localparam int N   = 128 >> k;
            localparam int OFF = 256 - (256 >> k);
            localparam int CH  = 256 - (512 >> k);
            for (j = 0; j < N; j++) begin : g_cell
                logic eh, lh, el, ll;
                if (k == 5) begin : g_src_stage
                    assign eh = e4_src[2*j+1];
                    assign lh = l4_src[2*j+1];
                    assign el = e4_src[2*j];
                    assign ll = l4_src[2*j];
                end else begin : g_src_tree
                    assign eh = e_n[CH+2*j+1];
                    assign lh = l_n[CH+2*j+1];
                    assign el = e_n[CH+2*j];
                    assign ll = l_n[CH+2*j];
                end
                assign e_n[OFF+j] = eh & el;
                assign l_n[OFF+j] = lh | (eh & ll);
            end
        end
    endgenerate

    // Differing sign bits can never be equal, so flipping the unsigned order keeps EQ=1 -> LT=0.
    assign eq_d  = e_n[254];
    assign ltu_d = l_n[254];
    assign lt_d  = l_n[254] ^ sgn_src;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
            ltu_q <= 1'b0;
        end else begin
            eq_q  <= eq_d;
            lt_q  <= lt_d;
            ltu_q <= ltu_d;
        end
    end

    assign EQ  = eq_q;
    assign LT  = lt_q;
    assign LTu = ltu_q;
endmodule

// File: tb/tb_comparator_tree128.sv
// Scoreboard bench for comparator_tree128: random + directed operands against a signed/unsigned compare model.
// Reads COMPARATOR_TREE128_PIPE_EN to pick the expected latency.
module tb_comparator_tree128;
`ifdef COMPARATOR_TREE128_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic         eq;
        logic         lt;
        logic         ltu;
        int           due;
    } exp_t;

    logic         clk, reset;
    logic [127:0] op1, op2;
    logic         EQ, LT, LTu;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 0;

    comparator_tree128 dut (
        .clk(clk), .reset(reset), .op1(op1), .op2(op2),
        .EQ(EQ), .LT(LT), .LTu(LTu)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: {EQ,LT,LTu} got %b want %b", nm, act, req);
        end
    endtask

    // Monitor: a result is due after the edge recorded at issue; otherwise outputs must be cleared.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("cmp a=%h b=%h", e.a, e.b), {EQ, LT, LTu}, {e.eq, e.lt, e.ltu});
            end else begin
                chk("idle_zero", {EQ, LT, LTu}, 3'b000);
            end
            checks++;
            if (EQ === 1'b1 && (LT !== 1'b0 || LTu !== 1'b0)) begin
                failures++;
                $display("FAIL invariant: EQ=%b LT=%b LTu=%b", EQ, LT, LTu);
            end
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called at posedge+1: drive operands, record expectation, advance one cycle.
    task automatic issue(input logic [127:0] a, input logic [127:0] b,
                         input logic eq, input logic lt, input logic ltu);
        exp_t e;
        op1 = a;
        op2 = b;
        e.a = a; e.b = b; e.eq = eq; e.lt = lt; e.ltu = ltu; e.due = cyc + LAT;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic issue_m(input logic [127:0] a, input logic [127:0] b);
        issue(a, b, a == b, $signed(a) < $signed(b), a < b);
    endtask

    initial begin
        logic [127:0] a, b, one, ones, msb;
        one  = 128'd1;
        ones = '1;
        msb  = one << 127;
        reset = 1;
        op1 = '0;
        op2 = '0;
        #3;
        chk("reset_async", {EQ, LT, LTu}, 3'b000);
        mon_en = 1;
        @(posedge clk);
        #1;
        reset = 0;

        issue('0, '0, 1'b1, 1'b0, 1'b0);
        issue(msb, one, 1'b0, 1'b1, 1'b0);
        issue(one, ones, 1'b0, 1'b0, 1'b1);
        issue(ones ^ one, ones, 1'b0, 1'b1, 1'b1);
        issue(ones, ones ^ one, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 128; i++) begin
            a = rnd128();
            b = a ^ (one << i);
            issue_m(a, a);
            issue_m(a, b);
            issue_m(b, a);
        end

        for (int i = 0; i < 8192; i++) begin
            a = rnd128();
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (one << $urandom_range(0, 127));
                default: b = rnd128();
            endcase
            if (i == 4000) begin
                #2;
                reset = 1;
                #1;
                chk("midstream_reset_async", {EQ, LT, LTu}, 3'b000);
                sb.delete();
                op1 = rnd128();
                op2 = rnd128();
                repeat (3) @(posedge clk);
                #1;
                reset = 0;
            end
            issue_m(a, b);
        end

        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        #1;
        mon_en = 0;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results never appeared, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
